// File: rtl/prog_clock_divider.sv
// Runtime-programmable modulo-N divider with tick, square wave, look-ahead carry
// and a one-shot timer mode; divisor changes are deferred to the next wrap/start.
module prog_clock_divider #(
    parameter int unsigned M = 8,
    parameter int unsigned N = 10
) (
    input  logic         CLK,
    input  logic         CLEAR,
    input  logic         EN,
    input  logic         MODE,
    input  logic         START,
    input  logic         LOAD,
    input  logic [M-1:0] DIV,
    output logic [M-1:0] COUNT,
    output logic         TICK,
    output logic         SQ,
    output logic         CARRY,
    output logic         BUSY
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } run_state_e;

    run_state_e   state_q, state_d;
    logic [M-1:0] count_q, count_d;
    logic [M-1:0] divr_q, divr_d;
    logic [M-1:0] pend_q, pend_d;
    logic         pend_v_q, pend_v_d;
    logic         tick_q, tick_d;
    logic         sq_q, sq_d;

    logic         adv, step, at_last, wrap, accept, apply;
    logic [M-1:0] load_val;
    logic [M:0]   half;

    always_comb begin
        adv      = !MODE || (state_q == S_RUN);
        step     = EN && adv;
        at_last  = (count_q == divr_q - M'(1));
        wrap     = step && at_last;
        accept   = START && MODE && (state_q == S_IDLE);
        apply    = wrap || accept;
        load_val = (DIV < M'(2)) ? M'(2) : DIV;

        state_d  = state_q;
        count_d  = count_q;
        divr_d   = divr_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        tick_d   = 1'b0;

        if (LOAD) begin
            pend_d   = load_val;
            pend_v_d = 1'b1;
        end
        // A same-cycle LOAD bypasses the pending register so the newest value wins.
        if (apply) begin
            if (LOAD) begin
                divr_d = load_val;
            end else if (pend_v_q) begin
                divr_d = pend_q;
            end
            pend_v_d = 1'b0;
        end

        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (wrap)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
            tick_d  = 1'b1;
        end else if (step) begin
            count_d = count_q + M'(1);
        end

        half = ({1'b0, divr_d} + (M+1)'(1)) >> 1;
        sq_d = ({1'b0, count_d} >= half);
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            divr_q   <= M'(N);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            divr_q   <= divr_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
        end
    end

    assign COUNT = count_q;
    assign TICK  = tick_q;
    assign SQ    = sq_q;
    assign BUSY  = (state_q == S_RUN);
    assign CARRY = wrap;

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Parametrised, runtime-programmable modulo-N clock divider: the general-purpose successor to the fixed divide-by-ten stage in the digital-clock datapath. It counts enabled cycles modulo a loadable divisor. It produces:
- a one-cycle tick,
- a registered square wave,
- a combinational look-ahead carry for chaining stages (e.g. 1 Hz → seconds → minutes),
- a one-shot timer mode with start/busy handshake.

## Interface

Parameters:
- M, 8: counter/divisor width in bits.
- N, 10: divisor loaded at reset; legal range 2 ≤ N ≤ 2^M−1.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  clock; all state changes on rising edge.
- CLEAR  input  1  synchronous active-high reset; dominates every other input.
- EN  input  1  count enable; COUNT advances only in cycles with EN=1.
- MODE  input  1  0 = free-running, 1 = one-shot.
- START  input  1  one-shot trigger; ignored when MODE=0 or BUSY=1.
- LOAD  input  1  capture DIV into pending-divisor register.
- DIV  input  M  new divisor value.
- COUNT  output  M  current count, 0..DIVR−1.
- TICK  output  1  registered; one-cycle pulse on wrap.
- SQ  output  1  registered square wave, period DIVR enabled cycles.
- CARRY  output  1  combinational: EN && ADV && COUNT==DIVR−1, for the next stage's EN.
- BUSY  output  1  one-shot run flag.

## Operation

- Internal state:
  - DIVR (active divisor, M bits)
  - PEND (M bits) plus PEND_V (valid flag)
  - RUN (BUSY) flag
- ADV = (MODE==0) || RUN. The counter advances in a cycle iff EN && ADV.
- Advance:
  - COUNT==DIVR−1 → wrap: COUNT←0, TICK←1.
  - Otherwise COUNT←COUNT+1, TICK←0.
- No advance: COUNT holds, TICK←0.
- SQ is computed from the next-state count: SQ=1 iff count ≥ ceil(DIVR/2). It is high for floor(DIVR/2) cycles and low for ceil(DIVR/2) cycles of each period. For odd DIVR, the low phase is the longer one.
- Divisor load:
  - LOAD=1 → PEND←max(DIV,2), PEND_V←1. A later LOAD before application overwrites PEND.
  - PEND is applied (DIVR←PEND, PEND_V←0) on a wrap, or on an accepted START.
  - The ongoing period always completes with the old DIVR. No truncated or glitched period.
  - A LOAD in the same cycle as a wrap applies the new DIV immediately: the new value wins over the old PEND.
- One-shot state machine (RUN):
  - IDLE (RUN=0): COUNT holds. START && MODE==1 → RUN=1 next cycle, COUNT=0, PEND applied.
  - RUN (RUN=1): counts while EN. On wrap: TICK=1, RUN←0, COUNT=0.
  - START while RUN=1 is ignored (no retrigger).
- MODE changes:
  - 1→0 takes effect immediately: counting resumes from the held COUNT.
  - 0→1 with RUN=0 freezes COUNT at its current value until START.
  - START resets COUNT to 0.
- Cascading: CARRY of stage k drives EN of stage k+1. Stage k+1 then advances in the same cycle that stage k wraps.

## Timing

- Reset values (CLEAR=1 at an edge): COUNT=0, TICK=0, SQ=0, RUN/BUSY=0, DIVR=N, PEND_V=0.
- CLEAR=1 mid-count or mid-run aborts immediately. No TICK is produced.
- Free-run, EN held high after CLEAR release: COUNT sequence 0,1,…,DIVR−1,0,…
  - TICK is high exactly in the cycles where COUNT returns to 0 after a wrap.
  - The first TICK occurs DIVR cycles after the first enabled edge.
- Tick rate: one TICK per DIVR enabled cycles. With EN gaps the period stretches by the gap count; TICK never repeats while held.
- One-shot latency: START accepted at edge t → BUSY=1 from t. With EN=1 continuously, TICK is high and BUSY drops at edge t+DIVR.
- CARRY is combinational, with zero latency from EN/COUNT. Depth is one compare plus an AND.
- Arithmetic: COUNT+1 is computed in M bits. Because DIVR ≤ 2^M−1, COUNT never overflows. The ceil(DIVR/2) compare uses M+1 bits.

## Test plan

- Reset/free-run, N=10, M=8, EN=1:
  - COUNT cycles 0..9.
  - TICK high for 1 cycle every 10 cycles, coincident with COUNT=0.
  - SQ low for 5 cycles, high for 5 cycles.
  - CARRY high only while COUNT=9.
- Deferred load:
  - At COUNT=3, pulse LOAD with DIV=4 → the period finishes through 9, then COUNT cycles 0..3 with TICK every 4 cycles.
  - DIV=1 is clamped: period 2.
  - DIV=7: SQ low 4 cycles, high 3 cycles.
- EN gaps: drop EN for 3 cycles at COUNT=5 → COUNT holds 5, CARRY=0, and the TICK interval measures 13 clocks.
- One-shot, DIVR=6:
  - START → BUSY=1; 6 cycles later TICK=1 and BUSY=0; COUNT stays 0 afterwards with EN=1.
  - START during BUSY is ignored.
- Cascade: two instances, N=10 and N=6, with stage 1 EN = stage 0 CARRY → stage 1 wraps every 60 clocks; its TICK is coincident with stage 0's TICK at that wrap.
- CLEAR mid-run: assert CLEAR at COUNT=7 with BUSY=1 and PEND_V=1 → next cycle all outputs are at reset values and DIVR=N (pending value discarded).
